// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer with pipeline stall.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_e;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT out of range");
    end

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              acc;

    // Byte offset is dropped: the memory is word-addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    assign acc = MemRead_i | MemWrite_i;

    // Next-state, datapath captures and the combinational stall.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall_o = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                stall_o = acc;
                if (acc) begin
                    addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    req_d   = 1'b1;
                    state_d = S_REQ;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_DONE: begin
                // EX/MEM still holds the finished instruction here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

`ifdef MEM_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl.
// Timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        ack = 1'b0;
    logic [31:0] mrdata = '0;
    logic        err;

    int n_checks = 0;
    int n_fail = 0;

    mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .MemRead_i(rd), .MemWrite_i(wr),
        .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall), .rdata_o(rdata),
        .mem_req_o(req), .mem_we_o(we),
        .mem_addr_o(maddr), .mem_wdata_o(mwdata),
        .mem_ack_i(ack), .mem_rdata_i(mrdata),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
        tick; tick;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0b want 0", req); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b want 0", we); end
        n_checks++; if (maddr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", maddr); end
        n_checks++; if (mwdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", mwdata); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", rdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", err); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b want 0", stall); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_load;
        int stalls = 0;
        rd = 1'b1; addr = 32'h0000_0013;
        #1;
        if (stall === 1'b1) stalls++;
        tick;
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL ld_req got %0b want 1", req); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL ld_we got %0b want 0", we); end
        n_checks++; if (maddr !== 32'h10) begin n_fail++; $display("FAIL ld_addr got %h want 10", maddr); end
        if (stall === 1'b1) stalls++;
        ack = 1'b1; mrdata = 32'hDEAD_BEEF;
        tick;
        ack = 1'b0; rd = 1'b0; mrdata = '0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_done_stall got %0b want 0", stall); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL ld_done_req got %0b want 1'b0", req); end
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_rdata got %h want deadbeef", rdata); end
        n_checks++; if (stalls != 2) begin n_fail++; $display("FAIL ld_stalls got %0d want 2", stalls); end
        tick;
        n_checks++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL ld_idle got req=%0b stall=%0b want 0 0", req, stall); end
    endtask

    task automatic test_store;
        int stalls = 0;
        int bad = 0;
        wr = 1'b1; addr = 32'h0000_0106; wdata = 32'h1234_5678;
        #1;
        if (stall === 1'b1) stalls++;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (req !== 1'b1 || we !== 1'b1 || maddr !== 32'h104 || mwdata !== 32'h1234_5678) bad++;
            if (stall === 1'b1) stalls++;
            if (i == 3) begin ack = 1'b1; mrdata = 32'h0000_0BAD; end
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL st_hold got %0d bad cycles want 0", bad); end
        tick;
        ack = 1'b0; wr = 1'b0; mrdata = '0;
        #1;
        n_checks++; if (stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL st_done got stall=%0b req=%0b want 0 0", stall, req); end
        n_checks++; if (stalls != 5) begin n_fail++; $display("FAIL st_stalls got %0d want 5", stalls); end
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_rdata got %h want deadbeef", rdata); end
        tick;
    endtask

    task automatic test_both;
        rd = 1'b1; wr = 1'b1; addr = 32'h0000_0022; wdata = 32'hA5A5_0F0F;
        tick;
        n_checks++; if (req !== 1'b1 || we !== 1'b1) begin n_fail++; $display("FAIL both_we got req=%0b we=%0b want 1 1", req, we); end
        n_checks++; if (maddr !== 32'h20 || mwdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL both_addr got %h %h want 20 a5a50f0f", maddr, mwdata); end
        ack = 1'b1; mrdata = 32'h0000_0055;
        tick;
        ack = 1'b0; rd = 1'b0; wr = 1'b0; mrdata = '0;
        n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL both_rdata got %h want deadbeef", rdata); end
        tick;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL both_single got req=%0b want 0", req); end
    endtask

    task automatic test_back_to_back;
        rd = 1'b1; addr = 32'h0000_0040;
        tick;
        ack = 1'b1; mrdata = 32'h1111_1111;
        tick;
        ack = 1'b0; mrdata = '0;
        rd = 1'b0; wr = 1'b1; addr = 32'h0000_0044; wdata = 32'h0000_2222;
        #1;
        n_checks++; if (stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL b2b_done got stall=%0b req=%0b want 0 0", stall, req); end
        n_checks++; if (rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_rdata got %h want 11111111", rdata); end
        tick;
        n_checks++; if (stall !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got stall=%0b req=%0b want 1 0", stall, req); end
        tick;
        n_checks++; if (req !== 1'b1 || we !== 1'b1 || maddr !== 32'h44) begin n_fail++; $display("FAIL b2b_req2 got req=%0b we=%0b addr=%h want 1 1 44", req, we, maddr); end
        ack = 1'b1;
        tick;
        ack = 1'b0; wr = 1'b0;
        tick;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int req_cycles = 0;
        rd = 1'b1; addr = 32'h0000_0200;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (req === 1'b1) req_cycles++;
            else break;
        end
        rd = 1'b0;
        #1;
        n_checks++; if (req_cycles != 8) begin n_fail++; $display("FAIL to_cycles got %0d want 8", req_cycles); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err got %0b want 1", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h want 0", rdata); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_done_stall got %0b want 0", stall); end
        tick;
        n_checks++; if (err !== 1'b1 || req !== 1'b0) begin n_fail++; $display("FAIL to_sticky got err=%0b req=%0b want 1 0", err, req); end
    endtask
`else
    task automatic test_no_timeout;
        rd = 1'b1; addr = 32'h0000_0200;
        for (int i = 0; i < 20; i++) tick;
        n_checks++; if (req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL wait_req got req=%0b stall=%0b want 1 1", req, stall); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wait_err got %0b want 0", err); end
        n_checks++; if (rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL wait_rdata got %h want 11111111", rdata); end
        rst = 1'b0; rd = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask
`endif

    task automatic test_mid_reset;
        rd = 1'b1; addr = 32'h0000_0080;
        tick;
        tick;
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL mr_req2 got %0b want 1", req); end
        rst = 1'b0; rd = 1'b0;
        tick;
        #1;
        n_checks++; if (req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL mr_drop got req=%0b stall=%0b want 0 0", req, stall); end
        n_checks++; if (err !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL mr_clear got err=%0b rdata=%h want 0 0", err, rdata); end
        rst = 1'b1; ack = 1'b1; mrdata = 32'h0000_0099;
        tick;
        ack = 1'b0; mrdata = '0;
        n_checks++; if (rdata !== 32'h0 || req !== 1'b0) begin n_fail++; $display("FAIL mr_late_ack got rdata=%h req=%0b want 0 0", rdata, req); end
        tick;
        n_checks++; if (stall !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL mr_idle got stall=%0b req=%0b want 0 0", stall, req); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_store;
        test_both;
        test_back_to_back;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
